// File: rtl/byte_lane_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : byte_lane_data_memory
//  Brief    : MIPS data memory with req/rsp handshake, byte/half/word
//             little-endian lane access, sign/zero-extended loads and
//             configurable wait states. Optional build macro:
//             DMEM_ALIGN_CHECK_EN (misaligned half/word -> error response;
//             otherwise low address bits are forced to the aligned lane).
//  Revision : 1.0 - initial release
// ============================================================================
module byte_lane_data_memory #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic        hold_we_q;
  logic [1:0]  hold_size_q;
  logic        hold_signed_q;
  logic [31:0] hold_addr_q;
  logic [31:0] hold_wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Word-organised RAM; zero at time zero, deliberately untouched by rst.
  logic [31:0] mem_q [WORDS] = '{default: 32'h0};

  // Fields of the access being performed this cycle
  logic                  acc_we;
  logic [1:0]            acc_size;
  logic                  acc_signed;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_range_err;
  logic                  acc_align_err;
  logic                  acc_err;
  logic [1:0]            acc_lane;
  logic [3:0]            acc_be;
  logic [31:0]           acc_wdata_sh;
  logic [31:0]           acc_rd_sh;
  logic [31:0]           acc_load;
  logic                  do_access;

  // With zero wait states the access happens on the accept edge itself,
  // so the live request is used; otherwise the captured copy is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we     = req_we;
      acc_size   = req_size;
      acc_signed = req_signed;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = hold_we_q;
      acc_size   = hold_size_q;
      acc_signed = hold_signed_q;
      acc_addr   = hold_addr_q;
      acc_wdata  = hold_wdata_q;
    end
  end

  assign acc_idx       = acc_addr[DEPTH_LOG2+1:2];
  assign acc_range_err = |(acc_addr >> (DEPTH_LOG2 + 2));

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_align_err = ((acc_size == 2'b01) && acc_addr[0]) ||
                         ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
  assign acc_align_err = 1'b0;
`endif

  assign acc_err = (acc_size == 2'b11) || acc_range_err || acc_align_err;

  // Lane selection, byte enables and lane-shifted data for both directions
  always_comb begin
    acc_lane = 2'b00;
    acc_be   = 4'b0000;
    case (acc_size)
      2'b00: begin
        acc_lane = acc_addr[1:0];
        acc_be   = 4'b0001 << acc_lane;
      end
      2'b01: begin
        acc_lane = {acc_addr[1], 1'b0};
        acc_be   = 4'b0011 << acc_lane;
      end
      2'b10: begin
        acc_lane = 2'b00;
        acc_be   = 4'b1111;
      end
      default: begin
        acc_lane = 2'b00;
        acc_be   = 4'b0000;
      end
    endcase
    acc_wdata_sh = acc_wdata << {acc_lane, 3'b000};
    acc_rd_sh    = mem_q[acc_idx] >> {acc_lane, 3'b000};
    case (acc_size)
      2'b00:   acc_load = acc_signed ? {{24{acc_rd_sh[7]}}, acc_rd_sh[7:0]}
                                     : {24'h0, acc_rd_sh[7:0]};
      2'b01:   acc_load = acc_signed ? {{16{acc_rd_sh[15]}}, acc_rd_sh[15:0]}
                                     : {16'h0, acc_rd_sh[15:0]};
      default: acc_load = acc_rd_sh;
    endcase
  end

  // The access fires on whichever edge moves the FSM into RESP
  assign do_access = ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST));

  // Lane-masked RAM write; a reset edge suppresses any pending store
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_be[k]) mem_q[acc_idx][8*k +: 8] <= acc_wdata_sh[8*k +: 8];
      end
    end
  end

  // Control FSM with request capture and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      hold_we_q     <= 1'b0;
      hold_size_q   <= 2'b00;
      hold_signed_q <= 1'b0;
      hold_addr_q   <= 32'h0;
      hold_wdata_q  <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (do_access) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_we || acc_err) ? 32'h0 : acc_load;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            hold_we_q     <= req_we;
            hold_size_q   <= req_size;
            hold_signed_q <= req_signed;
            hold_addr_q   <= req_addr;
            hold_wdata_q  <= req_wdata;
            wait_cnt_q    <= 4'd0;
            state_q       <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) state_q <= S_RESP;
          else                         wait_cnt_q <= wait_cnt_q + 4'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_lane_data_memory
//  Brief    : Self-checking bench: directed vector table and hand sequences
//             plus randomized traffic against a byte-array reference model.
//             Instance A runs with 0 wait states, instance B with 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_lane_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_ready, a_we, a_signed, a_rsp_valid, a_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rst, b_valid, b_ready, b_we, b_signed, b_rsp_valid, b_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  byte_lane_data_memory #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_size(a_size), .req_signed(a_signed),
    .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rdata), .rsp_err(a_err));

  byte_lane_data_memory #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_size(b_size), .req_signed(b_signed),
    .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata), .rsp_err(b_err));

  int errors = 0;
  int checks = 0;

  // Reference memories: one byte per byte address, 1024 bytes each
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [20];
  int   ntbl = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input logic [31:0] er_d, input logic er);
    tbl[ntbl].we = we; tbl[ntbl].size = sz; tbl[ntbl].sgn = sg;
    tbl[ntbl].addr = ad; tbl[ntbl].wdata = wd;
    tbl[ntbl].exp_rdata = er_d; tbl[ntbl].exp_err = er;
    ntbl++;
  endfunction

  // Byte-level model: range/size/alignment rules, then byte copy and extension
  function automatic void model(input bit on_b, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    int base;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    if (sz == 2'b11 || ad >= 32'd1024) begin
      er = 1'b1;
      return;
    end
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(ad);
    if (base % n != 0) begin
`ifdef DMEM_ALIGN_CHECK_EN
      er = 1'b1;
      return;
`else
      base = base - (base % n);
`endif
    end
    if (we) begin
      for (int i = 0; i < n; i++) begin
        if (on_b) mem_b[base+i] = wd[8*i +: 8];
        else      mem_a[base+i] = wd[8*i +: 8];
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++)
        v = v | ({24'h0, (on_b ? mem_b[base+i] : mem_a[base+i])} << (8*i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  // One transaction on A; starts and ends just after a clock edge in IDLE
  task automatic txn_a(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    a_valid = 1'b1; a_we = we; a_size = sz; a_signed = sg; a_addr = ad; a_wdata = wd;
    n = 0;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_valid = 1'b0; a_addr = $urandom; a_wdata = $urandom;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = a_rdata; er = a_err;
    @(posedge clk); #1;
  endtask

  task automatic txn_b(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    b_valid = 1'b1; b_we = we; b_size = sz; b_signed = sg; b_addr = ad; b_wdata = wd;
    n = 0;
    while (!b_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b_valid = 1'b0; b_addr = $urandom; b_wdata = $urandom;
    lat = 1;
    while (!b_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = b_rdata; er = b_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;
    int          acc_cyc [$];
    int          rsps;
    logic        saw;

    for (int i = 0; i < 1024; i++) begin mem_a[i] = 8'h0; mem_b[i] = 8'h0; end
    a_rst = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_size = 2'b00; a_signed = 1'b0;
    a_addr = 32'h0; a_wdata = 32'h0;
    b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_size = 2'b00; b_signed = 1'b0;
    b_addr = 32'h0; b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    check("reset_ready", {31'h0, a_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("reset_rdata", a_rdata, 32'h0);
    check("reset_err", {31'h0, a_err}, 32'h0);
    check("reset_ready_b", {31'h0, b_ready}, 32'h1);

    // Directed vectors on A (zero wait states)
    add(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(1, 2'b00, 0, 32'h12,  32'h00000055, 32'h0,        0);
    add(0, 2'b10, 0, 32'h10,  32'h0,        32'hDE55BEEF, 0);
    add(0, 2'b00, 1, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    add(0, 2'b00, 0, 32'h13,  32'h0,        32'h000000DE, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    add(0, 2'b01, 1, 32'h11,  32'h0,        32'h0,        1);
`else
    add(0, 2'b01, 1, 32'h11,  32'h0,        32'hFFFFBEEF, 0);
`endif
    add(1, 2'b10, 0, 32'h0,   32'h12345678, 32'h0,        0);
    add(1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h0,        1);
    add(0, 2'b10, 0, 32'h0,   32'h0,        32'h12345678, 0);
    add(0, 2'b11, 0, 32'h20,  32'h0,        32'h0,        1);
    add(1, 2'b11, 0, 32'h0,   32'hAAAAAAAA, 32'h0,        1);
    add(1, 2'b10, 0, 32'h80000000, 32'hBBBBBBBB, 32'h0,   1);
    add(0, 2'b10, 0, 32'h0,   32'h0,        32'h12345678, 0);
    add(1, 2'b01, 0, 32'h16,  32'h0000ABCD, 32'h0,        0);
    add(0, 2'b10, 0, 32'h14,  32'h0,        32'hABCD0000, 0);
    add(0, 2'b01, 0, 32'h16,  32'h0,        32'h0000ABCD, 0);
    add(0, 2'b01, 1, 32'h16,  32'h0,        32'hFFFFABCD, 0);

    for (int i = 0; i < ntbl; i++) begin
      model(1'b0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, erd, eer);
      txn_a(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // Three wait states: exact response cycle and req_ready low throughout
    b_valid = 1'b1; b_we = 1'b1; b_size = 2'b10; b_signed = 1'b0;
    b_addr = 32'h40; b_wdata = 32'hCAFEF00D;
    check("ws3_ready_before_accept", {31'h0, b_ready}, 32'h1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ws3_ready_T+%0d", k), {31'h0, b_ready}, 32'h0);
      check($sformatf("ws3_rsp_valid_T+%0d", k), {31'h0, b_rsp_valid}, {31'h0, (k == 4)});
      @(posedge clk); #1;
    end
    check("ws3_ready_after", {31'h0, b_ready}, 32'h1);
    model(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, erd, eer);
    txn_b(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("ws3_load_rdata", rd, 32'hCAFEF00D);
    check("ws3_load_latency", 32'(lat), 32'd4);

    // Reset during WAIT drops the store
    b_valid = 1'b1; b_we = 1'b1; b_size = 2'b10; b_addr = 32'h44; b_wdata = 32'h11111111;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (b_rsp_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_wait_no_rsp", {31'h0, saw}, 32'h0);
    check("rst_wait_ready", {31'h0, b_ready}, 32'h1);
    txn_b(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, rd, er, lat);
    check("rst_wait_store_dropped", rd, 32'h0);

    // Continuous req_valid: accept spacing and one response per accept
    b_valid = 1'b1; b_we = 1'b0; b_size = 2'b10; b_addr = 32'h40;
    rsps = 0;
    for (int c = 0; c < 40; c++) begin
      if (b_ready && b_valid) acc_cyc.push_back(c);
      if (b_rsp_valid) rsps++;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (b_rsp_valid) rsps++;
      @(posedge clk); #1;
    end
    check("hold_accept_count", 32'(acc_cyc.size()), 32'd8);
    check("hold_rsp_count", 32'(rsps), 32'(acc_cyc.size()));
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("hold_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      bit          on_b;
      on_b = (i % 5 == 4);
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 95));
      if ($urandom_range(0, 19) == 0) ad = 32'h3FC + 32'($urandom_range(0, 3));
      wd = $urandom;
      model(on_b, we, sz, sg, ad, wd, erd, eer);
      if (on_b) txn_b(we, sz, sg, ad, wd, rd, er, lat);
      else      txn_a(we, sz, sg, ad, wd, rd, er, lat);
      check($sformatf("rand%0d_rdata a=%h sz=%0d we=%0d", i, ad, sz, we), rd, erd);
      check($sformatf("rand%0d_err", i), {31'h0, er}, {31'h0, eer});
      check($sformatf("rand%0d_latency", i), 32'(lat), on_b ? 32'd4 : 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
